// File: rtl/vector_lane_engine_if.sv
// Operand stream in, lane results out, for vector_lane_engine.
// master = stream producer / result consumer, slave = the engine.
interface vector_lane_engine_if #(
  parameter int W     = 8,
  parameter int LANES = 4
);
  logic                 clr;
  logic                 din_valid;
  logic [W-1:0]         din;
  logic [1:0]           phase;
  logic [LANES*W-1:0]   dout;
  logic                 dout_valid;
  logic                 ovf;

  modport master (output clr, din_valid, din,
                  input  phase, dout, dout_valid, ovf);
  modport slave  (input  clr, din_valid, din,
                  output phase, dout, dout_valid, ovf);
endinterface

// File: rtl/vector_lane_engine.sv
// vector_lane_engine: serially loads LANES a, b and d operands, then computes
// per lane s = ((a*b) >>> SHIFT) + d and publishes all lanes at once.
// Optional macro VLE_SAT_EN: saturate lane results instead of wrapping.

// One lane: signed multiply, arithmetic shift, add, range check.
module vle_lane #(
  parameter int W     = 8,
  parameter int SHIFT = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] d,
  output logic [W-1:0] res,
  output logic         ovf
);
  localparam int PW = 2 * W;

  logic signed [PW-1:0] p, ps;
  logic signed [PW:0]   s;

  // Product shifted with floor rounding, then d added one bit wider so the
  // sum can never wrap before the range check.
  always_comb begin
    p   = $signed(a) * $signed(b);
    ps  = p >>> SHIFT;
    s   = {ps[PW-1], ps} + {{(W+1){d[W-1]}}, d};
    // fits in W bits iff the top bits down to the W-bit sign are all equal
    ovf = ~((&s[PW:W-1]) | ~(|s[PW:W-1]));
    res = s[W-1:0];
`ifdef VLE_SAT_EN
    if (ovf) res = s[PW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
  end
endmodule

module vector_lane_engine #(
  parameter int W     = 8,
  parameter int LANES = 4,
  parameter int SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vector_lane_engine_if.slave   bus
);
  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, LOAD_D = 2'd2} state_t;

  state_t                   state, state_nx;
  logic [IW-1:0]            idx, idx_nx;
  logic [LANES-1:0][W-1:0]  a_q, b_q, d_eff, res;
  // last lane's d is never stored: it is taken straight off din on the
  // edge that also latches the results
  logic [LANES-2:0][W-1:0]  d_q;
  logic [LANES-1:0]         lane_ovf;
  logic                     accept, last_beat;

  assign accept    = bus.din_valid & ~bus.clr;
  assign last_beat = accept & (state == LOAD_D) & (idx == LAST);
  assign bus.phase = state;

  // Next state / lane index; clr wins over any beat on the same edge.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (bus.clr) begin
      state_nx = LOAD_A;
      idx_nx   = '0;
    end else if (bus.din_valid) begin
      if (idx == LAST) begin
        idx_nx = '0;
        case (state)
          LOAD_A:  state_nx = LOAD_B;
          LOAD_B:  state_nx = LOAD_D;
          default: state_nx = LOAD_A;
        endcase
      end else begin
        idx_nx = idx + 1'b1;
      end
    end
  end

  // State and lane index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Operand capture into the lane selected by idx for the current phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      d_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (idx == IW'(i)) begin
          if (state == LOAD_A) a_q[i] <= bus.din;
          if (state == LOAD_B) b_q[i] <= bus.din;
        end
      end
      for (int i = 0; i < LANES - 1; i++) begin
        if (idx == IW'(i) && state == LOAD_D) d_q[i] <= bus.din;
      end
    end
  end

  // Lane d operands: stored lanes plus the live last beat.
  always_comb begin
    d_eff = '0;
    for (int i = 0; i < LANES - 1; i++) d_eff[i] = d_q[i];
    d_eff[LANES-1] = bus.din;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vle_lane #(.W(W), .SHIFT(SHIFT)) u_lane (
      .a   (a_q[g]),
      .b   (b_q[g]),
      .d   (d_eff[g]),
      .res (res[g]),
      .ovf (lane_ovf[g])
    );
  end

  // Result latch: dout/ovf only move on a completed group; pulse follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout       <= '0;
      bus.ovf        <= 1'b0;
      bus.dout_valid <= 1'b0;
    end else begin
      bus.dout_valid <= last_beat;
      if (last_beat) begin
        bus.dout <= res;
        bus.ovf  <= |lane_ovf;
      end
    end
  end
endmodule

// File: tb/tb_vector_lane_engine.sv
// Bench for vector_lane_engine: directed groups with literal expectations,
// then randomized beats/gaps/clr checked every cycle against a group model.
module tb_vector_lane_engine;
  localparam int W     = 8;
  localparam int L     = 4;
  localparam int SHIFT = 4;
  localparam int NB    = 3 * L;

  typedef int grp_t [NB];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_lane_engine_if #(.W(W), .LANES(L)) bus ();

  vector_lane_engine #(.W(W), .LANES(L), .SHIFT(SHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // group model: beats collected in arrays, results from integer arithmetic
  int ma [L];
  int mb [L];
  int md [L];
  int beat = 0;
  logic [L*W-1:0] e_dout = '0;
  logic e_valid = 1'b0;
  logic e_ovf = 1'b0;
  int acc_cnt = 0;
  int prev_pulse = 0;
  bit have_prev = 0;
  bit abort = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_compute();
    int p, q, s, r, dv, m, mn, mx;
    dv = 1 << SHIFT;
    m  = 1 << W;
    mn = -(1 << (W - 1));
    mx = (1 << (W - 1)) - 1;
    e_ovf = 1'b0;
    for (int i = 0; i < L; i++) begin
      p = ma[i] * mb[i];
      q = p / dv;
      if ((p % dv) != 0 && p < 0) q = q - 1;
      s = q + md[i];
      if (s < mn || s > mx) e_ovf = 1'b1;
`ifdef VLE_SAT_EN
      r = (s > mx) ? mx : (s < mn) ? mn : s;
`else
      r = ((s % m) + m) % m;
`endif
      e_dout[i*W +: W] = r[W-1:0];
    end
  endtask

  task automatic model_edge(input bit c, input bit v, input logic [W-1:0] x);
    e_valid = 1'b0;
    if (c) begin
      beat  = 0;
      abort = 1;
    end else if (v) begin
      acc_cnt++;
      case (beat / L)
        0:       ma[beat % L] = sx(x);
        1:       mb[beat % L] = sx(x);
        default: md[beat % L] = sx(x);
      endcase
      beat++;
      if (beat == NB) begin
        beat = 0;
        model_compute();
        e_valid = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    beat    = 0;
    e_dout  = '0;
    e_valid = 1'b0;
    e_ovf   = 1'b0;
    abort   = 1;
  endtask

  // drive at negedge, commit to the model at the posedge that samples it
  task automatic drive(input bit v, input bit c, input logic [W-1:0] x);
    @(negedge clk);
    bus.din_valid = v;
    bus.clr       = c;
    bus.din       = x;
    @(posedge clk);
    model_edge(c, v, x);
  endtask

  task automatic load_group(input grp_t g, input int gap_pct);
    for (int i = 0; i < NB; i++) begin
      while ($urandom_range(99) < gap_pct) drive(1'b0, 1'b0, W'($urandom));
      drive(1'b1, 1'b0, W'(g[i]));
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    chk("dout_valid", 64'(bus.dout_valid), 64'(e_valid));
    chk("dout", 64'(bus.dout), 64'(e_dout));
    chk("ovf", 64'(bus.ovf), 64'(e_ovf));
    chk("phase", 64'(bus.phase), 64'(beat / L));
    if (bus.dout_valid) begin
      if (have_prev && !abort) chk("pulse_gap", 64'(acc_cnt - prev_pulse), 64'(NB));
      prev_pulse = acc_cnt;
      have_prev  = 1;
      abort      = 0;
    end
  end

  grp_t g_basic = '{16, 0, -1, 2,   16, 0, 1, 3,   1, 5, 0, -3};
  grp_t g_ovf   = '{127, -128, 0, 0, -128, -128, 0, 0, 0, 127, 0, 0};
  logic [L*W-1:0] lit_basic = 32'hFDFF0511;
`ifdef VLE_SAT_EN
  logic [L*W-1:0] lit_ovf = 32'h00007F80;
`else
  logic [L*W-1:0] lit_ovf = 32'h00007F08;
`endif

  initial begin
    bus.din_valid = 1'b0;
    bus.clr       = 1'b0;
    bus.din       = '0;
    #12;
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_valid", 64'(bus.dout_valid), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    chk("rst_phase", 64'(bus.phase), 64'd0);
    #1 rst_n = 1'b1;

    // basic compute, then an overflow group back to back
    load_group(g_basic, 0);
    #1;
    chk("basic_valid", 64'(bus.dout_valid), 64'd1);
    chk("basic_dout", 64'(bus.dout), 64'(lit_basic));
    chk("basic_ovf", 64'(bus.ovf), 64'd0);
    load_group(g_ovf, 0);
    #1;
    chk("ovf_dout", 64'(bus.dout), 64'(lit_ovf));
    chk("ovf_flag", 64'(bus.ovf), 64'd1);

    // same basic group with random gaps
    load_group(g_basic, 40);
    #1;
    chk("gap_dout", 64'(bus.dout), 64'(lit_basic));
    drive(1'b0, 1'b0, '0);

    // clr in phase B at index 2, beat on the same edge dropped
    for (int i = 0; i < L + 2; i++) drive(1'b1, 1'b0, W'(g_ovf[i]));
    drive(1'b1, 1'b1, 8'h55);
    #1;
    chk("clr_phase", 64'(bus.phase), 64'd0);
    chk("clr_keep", 64'(bus.dout), 64'(lit_basic));
    load_group(g_ovf, 20);
    #1;
    chk("clr_after", 64'(bus.dout), 64'(lit_ovf));

    // clr coinciding with the last D beat yields no result
    for (int i = 0; i < NB - 1; i++) drive(1'b1, 1'b0, W'(g_basic[i]));
    drive(1'b1, 1'b1, W'(g_basic[NB-1]));
    #1;
    chk("clr_last_valid", 64'(bus.dout_valid), 64'd0);
    chk("clr_last_keep", 64'(bus.dout), 64'(lit_ovf));

    // asynchronous reset in the middle of LOAD_D
    for (int i = 0; i < 2 * L + 2; i++) drive(1'b1, 1'b0, W'(g_basic[i]));
    #2;
    rst_n = 1'b0;
    bus.din_valid = 1'b0;
    model_reset();
    #1;
    chk("mrst_dout", 64'(bus.dout), 64'd0);
    chk("mrst_ovf", 64'(bus.ovf), 64'd0);
    chk("mrst_phase", 64'(bus.phase), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    load_group(g_basic, 10);
    #1;
    chk("mrst_after", 64'(bus.dout), 64'(lit_basic));

    // randomized beats, gaps and occasional clr
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(99) < 70, $urandom_range(99) < 3, W'($urandom));
    drive(1'b0, 1'b0, '0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
